// File: rtl/bnn_fc_infer.sv
// bnn_fc_infer: single binary fully-connected layer (XNOR-popcount per class) with argmax over a buffered image.
// Latency: result_valid is high NUM_CLASSES*CHUNKS+2 cycles after the accept cycle (accept, RUN beats, DRAIN, RESULT).
// Backpressure: result is held in RESULT until result_ready; img_ready stays low until the result is taken.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   img_in/img_valid/img_ready        flattened binarised image input handshake
//   weight_en/weight_addr/weight_data synchronous weight memory read port (data one cycle after enable)
//   clear                 synchronous abort back to IDLE
//   busy                  high while weight rows are being fetched or the final beat is processed
//   result_valid/result_ready/result_class/result_score  argmax result handshake
module bnn_fc_infer #(
   parameter int IMG_BITS    = 784,
   parameter int NUM_CLASSES = 10,
   parameter int CHUNK       = 16,
   localparam int CHUNKS     = IMG_BITS / CHUNK,
   localparam int AW         = $clog2(NUM_CLASSES * CHUNKS),
   localparam int SW         = $clog2(IMG_BITS + 1),
   localparam int CW         = $clog2(NUM_CLASSES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IMG_BITS-1:0] img_in,
   input  logic                img_valid,
   output logic                img_ready,
   output logic                weight_en,
   output logic [AW-1:0]       weight_addr,
   input  logic [CHUNK-1:0]    weight_data,
   input  logic                clear,
   output logic                busy,
   output logic                result_valid,
   input  logic                result_ready,
   output logic [CW-1:0]       result_class,
   output logic [SW-1:0]       result_score
);

   if ((IMG_BITS % CHUNK) != 0) begin : g_chunk_check
      $error("bnn_fc_infer: IMG_BITS must be a multiple of CHUNK");
   end

   localparam int CKW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESULT} state_t;

   state_t              state, state_nx;
   logic [IMG_BITS-1:0] img_rot;      // latched image, rotated so the current chunk sits in the low bits
   logic [CKW-1:0]      chunk_cnt;    // issue side: chunk of the address being sent
   logic [CW-1:0]       class_cnt;    // issue side: class of the address being sent
   logic                d_vld;        // data side: weight_data is valid this cycle
   logic                d_last;       // data side: this beat closes a class
   logic [CW-1:0]       d_class;
   logic [SW-1:0]       acc;
   logic [SW-1:0]       best_score;
   logic [CW-1:0]       best_class;

   logic                accept, last_chunk, last_issue, take;
   logic [SW-1:0]       chunk_term, class_score, best_score_nx;
   logic [CW-1:0]       best_class_nx;

   function automatic logic [SW-1:0] popcnt(input logic [CHUNK-1:0] v);
      logic [SW-1:0] n;
      n = '0;
      for (int j = 0; j < CHUNK; j++) n = n + SW'(v[j]);
      return n;
   endfunction

   assign accept     = (state == S_IDLE) && img_valid && !clear;
   assign last_chunk = (chunk_cnt == CKW'(CHUNKS - 1));
   assign last_issue = last_chunk && (class_cnt == CW'(NUM_CLASSES - 1));

   // Score path for the beat currently on weight_data.
   always_comb begin
      chunk_term    = popcnt(~(img_rot[CHUNK-1:0] ^ weight_data));
      class_score   = acc + chunk_term;
      // Strictly greater: on a tie the earlier (lower) class keeps the win.
      take          = d_vld && d_last && (class_score > best_score);
      best_score_nx = take ? class_score : best_score;
      best_class_nx = take ? d_class : best_class;
   end

   always_comb begin
      state_nx     = state;
      img_ready    = 1'b0;
      weight_en    = 1'b0;
      busy         = 1'b0;
      result_valid = 1'b0;
      case (state)
         S_IDLE: begin
            img_ready = !clear;
            if (accept) state_nx = S_RUN;
         end
         S_RUN: begin
            weight_en = 1'b1;
            busy      = 1'b1;
            if (last_issue) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            busy     = 1'b1;
            state_nx = S_RESULT;
         end
         S_RESULT: begin
            result_valid = 1'b1;
            if (result_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (clear) state_nx = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         img_rot      <= '0;
         chunk_cnt    <= '0;
         class_cnt    <= '0;
         weight_addr  <= '0;
         d_vld        <= 1'b0;
         d_last       <= 1'b0;
         d_class      <= '0;
         acc          <= '0;
         best_score   <= '0;
         best_class   <= '0;
         result_class <= '0;
         result_score <= '0;
      end else begin
         state   <= state_nx;
         d_vld   <= weight_en && !clear;
         d_last  <= last_chunk;
         d_class <= class_cnt;
         if (accept) begin
            img_rot     <= img_in;
            chunk_cnt   <= '0;
            class_cnt   <= '0;
            weight_addr <= '0;
            acc         <= '0;
            best_score  <= '0;
            best_class  <= '0;
         end else begin
            // Address stays on its last value once the final word is issued.
            if (weight_en && !last_issue) begin
               weight_addr <= weight_addr + AW'(1);
               if (last_chunk) begin
                  chunk_cnt <= '0;
                  class_cnt <= class_cnt + CW'(1);
               end else begin
                  chunk_cnt <= chunk_cnt + CKW'(1);
               end
            end
            if (d_vld) begin
               // Rotating by one chunk per beat returns to chunk 0 after each class.
               img_rot    <= (img_rot >> CHUNK) | (img_rot << (IMG_BITS - CHUNK));
               acc        <= d_last ? '0 : class_score;
               best_score <= best_score_nx;
               best_class <= best_class_nx;
            end
            // The final beat is folded in during DRAIN, so load from the bypassed best.
            if (state == S_DRAIN && !clear) begin
               result_class <= best_class_nx;
               result_score <= best_score_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_bnn_fc_infer.sv
module tb_bnn_fc_infer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct packed {logic [15:0] cls; logic [15:0] scr;} exp_t;

   // ---------------- small instance: IMG_BITS=8, CHUNK=4, NUM_CLASSES=3
   logic [7:0] img_in_s;
   logic       img_valid_s, img_ready_s, weight_en_s, clear_s, busy_s;
   logic [2:0] weight_addr_s;
   logic [3:0] weight_data_s;
   logic       result_valid_s, result_ready_s;
   logic [1:0] result_class_s;
   logic [3:0] result_score_s;

   bnn_fc_infer #(.IMG_BITS(8), .NUM_CLASSES(3), .CHUNK(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .img_in(img_in_s), .img_valid(img_valid_s), .img_ready(img_ready_s),
      .weight_en(weight_en_s), .weight_addr(weight_addr_s), .weight_data(weight_data_s),
      .clear(clear_s), .busy(busy_s), .result_valid(result_valid_s), .result_ready(result_ready_s),
      .result_class(result_class_s), .result_score(result_score_s));

   logic [7:0] wrow_s [3];
   function automatic logic [3:0] sword(input logic [2:0] a);
      logic [7:0] row;
      if (a > 3'd5) return 4'h0;
      row = wrow_s[a >> 1];
      return a[0] ? row[7:4] : row[3:0];
   endfunction
   // Outside an enabled read, the memory output is junk so late/early sampling shows up.
   always @(posedge clk) weight_data_s <= weight_en_s ? sword(weight_addr_s) : 4'($urandom);

   exp_t sq_s[$];
   exp_t pend_s;
   int   acc_cyc_s, en_cnt_s, exp_addr_s;
   logic rv_prev_s = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (img_valid_s && img_ready_s) begin
            acc_cyc_s = cyc; en_cnt_s = 0; exp_addr_s = 0;
            sq_s.push_back(pend_s);
         end
         if (weight_en_s) begin
            chk("addr_seq_s", weight_addr_s, exp_addr_s);
            exp_addr_s++; en_cnt_s++;
         end
         if (result_valid_s && !rv_prev_s) begin
            chk("latency_s", cyc - acc_cyc_s, 8);
            chk("en_cycles_s", en_cnt_s, 6);
         end
         if (result_valid_s && result_ready_s) begin
            if (sq_s.size() == 0) chk("sb_unexpected_s", 1, 0);
            else begin
               e = sq_s.pop_front();
               chk("class_s", result_class_s, e.cls);
               chk("score_s", result_score_s, e.scr);
            end
         end
      end
      rv_prev_s = result_valid_s;
   end

   // ---------------- default instance: 784 / 10 / 16
   logic [783:0] img_in_d;
   logic         img_valid_d, img_ready_d, weight_en_d, clear_d, busy_d;
   logic [8:0]   weight_addr_d;
   logic [15:0]  weight_data_d;
   logic         result_valid_d, result_ready_d;
   logic [3:0]   result_class_d;
   logic [9:0]   result_score_d;

   bnn_fc_infer dut_d (
      .clk(clk), .rst_n(rst_n), .img_in(img_in_d), .img_valid(img_valid_d), .img_ready(img_ready_d),
      .weight_en(weight_en_d), .weight_addr(weight_addr_d), .weight_data(weight_data_d),
      .clear(clear_d), .busy(busy_d), .result_valid(result_valid_d), .result_ready(result_ready_d),
      .result_class(result_class_d), .result_score(result_score_d));

   logic [15:0] wmem_d [490];
   always @(posedge clk) weight_data_d <= weight_en_d ? wmem_d[weight_addr_d] : 16'($urandom);

   exp_t sq_d[$];
   exp_t pend_d;
   int   acc_cyc_d, en_cnt_d, exp_addr_d;
   logic rv_prev_d = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (img_valid_d && img_ready_d) begin
            acc_cyc_d = cyc; en_cnt_d = 0; exp_addr_d = 0;
            sq_d.push_back(pend_d);
         end
         if (weight_en_d) begin
            if (weight_addr_d != exp_addr_d[8:0]) chk("addr_seq_d", weight_addr_d, exp_addr_d);
            exp_addr_d++; en_cnt_d++;
         end
         if (result_valid_d && !rv_prev_d) begin
            chk("latency_d", cyc - acc_cyc_d, 492);
            chk("en_cycles_d", en_cnt_d, 490);
         end
         if (result_valid_d && result_ready_d) begin
            if (sq_d.size() == 0) chk("sb_unexpected_d", 1, 0);
            else begin
               e = sq_d.pop_front();
               chk("class_d", result_class_d, e.cls);
               chk("score_d", result_score_d, e.scr);
            end
         end
      end
      rv_prev_d = result_valid_d;
   end

   // Reference: per-class XNOR count over all pixels, strict-greater argmax from class 0 / score 0.
   function automatic exp_t ref_d(input logic [783:0] img);
      int best, bc, s;
      exp_t r;
      best = 0; bc = 0;
      for (int c = 0; c < 10; c++) begin
         s = 0;
         for (int i = 0; i < 784; i++)
            if (wmem_d[c*49 + i/16][i%16] == img[i]) s++;
         if (s > best) begin best = s; bc = c; end
      end
      r.cls = 16'(bc); r.scr = 16'(best);
      return r;
   endfunction

   // ---------------- drivers
   typedef struct {
      logic [7:0] img, w0, w1, w2;
      int         cls, scr;
   } vec_t;
   vec_t vt[7];

   task automatic send_s(input vec_t v);
      logic ok;
      ok = 1'b0;
      wrow_s[0] = v.w0; wrow_s[1] = v.w1; wrow_s[2] = v.w2;
      pend_s.cls = 16'(v.cls); pend_s.scr = 16'(v.scr);
      @(posedge clk); #1;
      img_in_s = v.img; img_valid_s = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (img_ready_s) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout_s", 0, 1);
      @(posedge clk); #1;
      img_valid_s = 1'b0; img_in_s = ~v.img;
   endtask

   task automatic drain_s();
      for (int i = 0; i < 100 && sq_s.size() != 0; i++) @(negedge clk);
      if (sq_s.size() != 0) begin
         chk("sb_timeout_s", sq_s.size(), 0);
         sq_s.delete();
      end
   endtask

   task automatic run_d(input logic [783:0] img);
      logic ok;
      ok = 1'b0;
      pend_d = ref_d(img);
      @(posedge clk); #1;
      img_in_d = img; img_valid_d = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (img_ready_d) begin ok = 1'b1; break; end
      end
      if (!ok) chk("accept_timeout_d", 0, 1);
      @(posedge clk); #1;
      img_valid_d = 1'b0; img_in_d = ~img;
      for (int i = 0; i < 700 && sq_d.size() != 0; i++) @(negedge clk);
      if (sq_d.size() != 0) begin
         chk("sb_timeout_d", sq_d.size(), 0);
         sq_d.delete();
      end
   endtask

   initial begin
      logic [783:0] img;
      logic [1:0]   cap_cls;
      logic [3:0]   cap_scr;
      logic         seen;

      vt[0] = '{8'hFF, 8'h0F, 8'hFF, 8'h00, 1, 8};
      vt[1] = '{8'hF0, 8'hF0, 8'h0F, 8'hF0, 0, 8};
      vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 8};
      vt[3] = '{8'hA5, 8'h00, 8'h5A, 8'hA5, 2, 8};
      vt[4] = '{8'h3C, 8'h3F, 8'hFC, 8'h3D, 2, 7};
      vt[5] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 0, 0};
      vt[6] = '{8'h81, 8'h01, 8'h81, 8'h80, 1, 8};

      rst_n = 1'b0;
      img_in_s = '0; img_valid_s = 1'b0; clear_s = 1'b0; result_ready_s = 1'b1;
      img_in_d = '0; img_valid_d = 1'b0; clear_d = 1'b0; result_ready_d = 1'b1;
      wrow_s[0] = '0; wrow_s[1] = '0; wrow_s[2] = '0;
      for (int k = 0; k < 490; k++) wmem_d[k] = 16'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_img_ready", img_ready_s, 1);
      chk("rst_weight_en", weight_en_s, 0);
      chk("rst_weight_addr", weight_addr_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_result_valid", result_valid_s, 0);
      chk("rst_result_class", result_class_s, 0);
      chk("rst_result_score", result_score_s, 0);
      rst_n = 1'b1;

      // Table: basic, tie, all-zero, assorted patterns.
      for (int i = 0; i < 7; i++) begin
         send_s(vt[i]);
         drain_s();
      end

      // Backpressure: hold the result, offer a new image meanwhile.
      result_ready_s = 1'b0;
      send_s(vt[0]);
      for (int i = 0; i < 40 && !result_valid_s; i++) @(negedge clk);
      chk("bp_valid_rise", result_valid_s, 1);
      cap_cls = result_class_s; cap_scr = result_score_s;
      chk("bp_cap_class", cap_cls, 1);
      @(posedge clk); #1;
      wrow_s[0] = vt[6].w0; wrow_s[1] = vt[6].w1; wrow_s[2] = vt[6].w2;
      pend_s.cls = 16'(vt[6].cls); pend_s.scr = 16'(vt[6].scr);
      img_in_s = vt[6].img; img_valid_s = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid_hold", result_valid_s, 1);
         chk("bp_class_hold", result_class_s, cap_cls);
         chk("bp_score_hold", result_score_s, cap_scr);
         chk("bp_img_ready_low", img_ready_s, 0);
      end
      @(posedge clk); #1;
      result_ready_s = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_img_ready", img_ready_s, 1);
      chk("bp_release_valid", result_valid_s, 0);
      @(posedge clk); #1;
      img_valid_s = 1'b0;
      chk("bp_second_busy", busy_s, 1);
      drain_s();

      // Abort in RUN cycle 3.
      send_s(vt[4]);
      @(posedge clk); #1;
      @(posedge clk); #1;
      clear_s = 1'b1;
      @(posedge clk); #1;
      clear_s = 1'b0;
      chk("clr_weight_en", weight_en_s, 0);
      chk("clr_busy", busy_s, 0);
      chk("clr_result_valid", result_valid_s, 0);
      sq_s.delete();
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (result_valid_s) seen = 1'b1;
      end
      chk("clr_no_result", seen, 0);
      send_s(vt[3]);
      drain_s();

      // Synchronous reset in the middle of a run.
      send_s(vt[0]);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mrst_img_ready", img_ready_s, 1);
      chk("mrst_weight_en", weight_en_s, 0);
      chk("mrst_weight_addr", weight_addr_s, 0);
      chk("mrst_busy", busy_s, 0);
      chk("mrst_result_valid", result_valid_s, 0);
      chk("mrst_result_class", result_class_s, 0);
      chk("mrst_result_score", result_score_s, 0);
      rst_n = 1'b1;
      sq_s.delete();

      // A reset pulse between edges must be ignored.
      send_s(vt[4]);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("glitch_busy", busy_s, 1);
      drain_s();

      // Default geometry: random images, then duplicated rows to force a known winner and a tie.
      for (int n = 0; n < 2; n++) begin
         for (int k = 0; k < 49; k++) img[k*16 +: 16] = 16'($urandom);
         run_d(img);
      end
      for (int k = 0; k < 49; k++) img[k*16 +: 16] = 16'($urandom);
      for (int k = 0; k < 49; k++) begin
         wmem_d[7*49 + k] = img[k*16 +: 16];
         wmem_d[3*49 + k] = img[k*16 +: 16];
      end
      chk("model_tie_class", ref_d(img).cls, 3);
      run_d(img);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_fc_infer.md
Name: bnn_fc_infer

Overview:
Parameterised successor to the fixed-result BNN interface. Runs a real single binary fully-connected layer over a buffered binarised image: for each class it computes XNOR-popcount against a weight row fetched from an external synchronous weight memory, then returns the argmax class and its score. Sits between the image buffer, which provides the full flattened image plus a valid signal, and the result/display path, using valid/ready handshakes on both sides.

Parameters:
IMG_BITS, 784, image pixels (bits); must be divisible by CHUNK, otherwise elaboration error
NUM_CLASSES, 10, output classes (>=2)
CHUNK, 16, image/weight bits processed per cycle
CHUNKS (derived), IMG_BITS/CHUNK
AW (derived), $clog2(NUM_CLASSES*CHUNKS)
SW (derived), $clog2(IMG_BITS+1), score width
CW (derived), $clog2(NUM_CLASSES), class width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
img_in  in  IMG_BITS  flattened image; bit i = pixel i
img_valid  in  1  image available
img_ready  out  1  block accepts image
weight_en  out  1  weight memory read enable
weight_addr  out  AW  weight word address = class*CHUNKS + chunk
weight_data  in  CHUNK  word read; valid exactly 1 cycle after weight_en; bit j maps to pixel chunk*CHUNK+j
clear  in  1  synchronous abort
busy  out  1  high in RUN or DRAIN
result_valid  out  1  result available
result_ready  in  1  consumer takes result
result_class  out  CW  argmax class
result_score  out  SW  winning popcount

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; img_ready=1, weight_en=0, weight_addr=0, busy=0, result_valid=0, result_class=0, result_score=0; accumulators and counters cleared.
- IDLE: img_ready=1. Accept on img_valid&&img_ready. At that edge, latch img_in into an internal register, zero the counters, set best_score=0 and best_class=0, then go to RUN. Later changes to img_in do not affect the run.
- RUN: NUM_CLASSES*CHUNKS consecutive cycles with weight_en=1. Addresses issue 0,1,2,… in order, with no gaps. img_ready=0.
- Datapath, one cycle behind the address: acc += popcount(~(img_chunk ^ weight_data)). On the last chunk of a class, the class score is acc + that chunk's term. Compare it with best: strictly greater replaces best, so a tie keeps the lower class index. Then reset acc.
- DRAIN: one cycle for the final data beat; weight_en=0. Next state is RESULT.
- RESULT: result_valid=1; result_class and result_score are stable until the handshake. Leave RESULT at the edge where result_valid&&result_ready, returning to IDLE. img_ready=0 while in RESULT; there is no overlap with the next image.
- Latency: result_valid rises exactly NUM_CLASSES*CHUNKS+2 cycles after the accept edge (492 at the defaults).
- result_class/result_score hold their last values after the handshake until the next result is loaded.
- clear: in any state it forces IDLE next cycle, with weight_en=0, busy=0, result_valid=0. Any pending result is discarded. clear takes priority over img_valid and result_ready in the same cycle. rst_n takes priority over clear.
- Arithmetic: all scores are unsigned SW bits. Maximum score is IMG_BITS, so there is no overflow.
- weight_addr is held at its last value when weight_en=0.

Test Plan:
1. Params IMG_BITS=8, CHUNK=4, NUM_CLASSES=3. img=8'hFF; weight rows c0=8'h0F, c1=8'hFF, c2=8'h00 -> result_class=1, result_score=8. result_valid rises 8 cycles after accept. weight_addr sequence is 0..5.
2. Tie, same params. img=8'hF0; c0=8'hF0, c1=8'h0F, c2=8'hF0 -> class 0, score 8. All-zero weights with img=8'h00 -> class 0, score 8.
3. Backpressure: hold result_ready=0 for 5 cycles after result_valid rises -> class/score/valid stable, img_ready=0, and a held img_valid is not accepted. Release -> IDLE next cycle, img_ready=1.
4. Mid-run abort: assert clear in RUN cycle 3 -> next cycle weight_en=0, busy=0, no result_valid. A new image is accepted normally and gives the correct result.
5. Reset mid-run: drive rst_n low in RUN -> all outputs at reset values after that edge. An asynchronous glitch on rst_n between edges has no effect.
6. Defaults with random img and weights vs a reference model -> class/score match, latency 492, exactly 490 weight_en cycles.
